decode_ctrl_stage: RTL
======================

# decode_ctrl_stage

Registered, parametrised instruction-decode stage for the single-issue CPU. It sits between instruction fetch and the register file, ALU and data-memory ports, and replaces the purely reactive decoder.
- Adds a valid/ready handshake with fetch, a FLUSH input for taken branches and jumps, and extended opcodes (bne, shifts, rotate, mult).
- Holds memory commands across data-memory BUSYWAIT stalls and pulses register write-back for loads only on completion.
- Keeps a retired-instruction counter.

## Interface
- REG_ADDR_W, 3: register address width; selects INSTR bits [REG_ADDR_W-1:0] of each byte field.
- IMM_W, 8: immediate width, taken from INSTR[IMM_W-1:0]; legal range 1..8.
- CNT_W, 16: retired-instruction counter width.
- CLK  in  1  rising-edge clock.
- RESET  in  1  reset: synchronous, active-high.
- INSTR  in  32  {opcode[31:24], dest[23:16], src1[15:8], src2/imm[7:0]}.
- INSTR_VALID  in  1  fetch offers INSTR.
- INSTR_READY  out  1  stage accepts INSTR at this edge.
- FLUSH  in  1  discard the instruction accepted at this edge.
- BUSYWAIT  in  1  data-memory stall. Memory raises it combinationally in the same cycle READ/WRITE rise.
- READREG1, READREG2, WRITEREG  out  REG_ADDR_W  register file addresses.
- IMMEDIATE  out  IMM_W  immediate field.
- ALUOP  out  4  0 fwd, 1 add, 2 and, 3 or, 4 sll, 5 srl, 6 sra, 7 ror, 8 mult.
- MUX_2C, MUX_IM, SEL_MUX_WRITE  out  1 each  negate operand 2; 1 = register operand / 0 = immediate; 1 = ALU result / 0 = memory data.
- BRANCH, BRANCH_NE, JUMP  out  1 each  beq / bne / jump indicators.
- WRITEENABLE  out  1  register file write strobe.
- READ, WRITE  out  1 each  data-memory commands.
- OUT_VALID  out  1  decoded outputs are live.
- ILLEGAL  out  1  decoded opcode was unknown.
- RETIRED  out  CNT_W  completed-instruction count.

## Operation
- Opcodes and ALUOP:
  - loadi 0x00: ALUOP 0, MUX_IM=0.
  - mov 0x01: ALUOP 0.
  - add 0x02: ALUOP 1.
  - sub 0x03: ALUOP 1, MUX_2C=1.
  - and 0x04: ALUOP 2.
  - or 0x05: ALUOP 3.
  - j 0x06: JUMP.
  - beq 0x07: BRANCH, ALUOP 1, MUX_2C=1.
  - lwd 0x08 / lwi 0x09: READ, SEL_MUX_WRITE=0; lwi has MUX_IM=0.
  - swd 0x0A / swi 0x0B: WRITE; swi has MUX_IM=0.
  - bne 0x0C: BRANCH_NE, ALUOP 1, MUX_2C=1.
  - sll 0x0D, srl 0x0E, sra 0x0F, ror 0x10: ALUOP 4..7, MUX_IM=0.
  - mult 0x11: ALUOP 8.
- Write-enable class: ALU ops, mov, loadi, mult and loads write the register file. Stores, branches and jump do not.
- Unknown opcode: ILLEGAL=1. WRITEENABLE, READ, WRITE, BRANCH, BRANCH_NE and JUMP are all 0. The instruction still retires in one cycle.
- FSM states and transitions:
  - IDLE: OUT_VALID=0.
  - EXEC: non-memory instruction live for exactly one cycle.
  - MEM: load or store live; held while BUSYWAIT=1.
- Accept occurs when INSTR_VALID & INSTR_READY & !FLUSH at an edge. Next state is MEM for opcodes 0x08–0x0B, otherwise EXEC.
- No accept at an edge: next state is IDLE.
- INSTR_READY = !RESET & !(state==MEM & BUSYWAIT).
- WRITEENABLE = OUT_VALID & we_class & (state!=MEM | !BUSYWAIT). For loads, write-back is only the final MEM cycle.
- READ/WRITE are asserted for the whole MEM residency and drop at the edge that leaves MEM.
- FLUSH:
  - FLUSH at an edge blocks the accept, giving a bubble (IDLE).
  - FLUSH while in MEM with BUSYWAIT=1 is ignored; a memory operation is never cancelled.
- RETIRED increments by 1 at each edge ending an EXEC cycle, or a MEM cycle with BUSYWAIT=0. It wraps modulo 2^CNT_W.

## Timing
- Decode latency is 1 cycle: INSTR accepted at edge n drives outputs in cycle n+1.
- Back-to-back throughput is 1 instruction per cycle when there are no stalls.
- A memory op with k BUSYWAIT cycles occupies MEM for k+1 cycles. INSTR_READY is low for the k stalled cycles.
- RESET at an edge (including mid-MEM):
  - state goes to IDLE; all decoded registers, outputs and RETIRED go to 0;
  - READ and WRITE drop in the next cycle;
  - INSTR_READY=0 while RESET=1.
- RESET has priority over FLUSH and accept.
- WRITEENABLE and INSTR_READY are combinational from registered state and BUSYWAIT. All other outputs are registered.

## Test plan
- Reset then add: RESET 2 cycles, then INSTR 0x02030102 valid → next cycle OUT_VALID=1, ALUOP=1, WRITEREG=3, READREG1=1, READREG2=2, WRITEENABLE=1. RETIRED=1 afterward.
- Load stall: lwi 0x09040037 with BUSYWAIT high 3 cycles → READ=1 for 4 cycles, IMMEDIATE=0x37, WRITEENABLE=1 only in the 4th cycle, INSTR_READY=0 for 3 cycles.
- Flush: beq accepted, then FLUSH=1 with the next valid instruction → one IDLE cycle with OUT_VALID=0. RETIRED counts only the beq.
- Flush during store stall: swd with BUSYWAIT=1 and FLUSH=1 → WRITE stays 1 until BUSYWAIT falls; the store retires.
- Illegal/extended: opcode 0xFF → ILLEGAL=1, all enables 0. Opcode 0x0F → ALUOP=6, MUX_IM=0, WRITEENABLE=1.
- Reset mid-MEM and counter wrap: RESET during lwd stall → READ=0 next cycle, RETIRED=0. With CNT_W=4, 17 add instructions → RETIRED=1.

Source files
------------

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage
// Registered instruction-decode stage for the single-issue CPU.
// It sits between instruction fetch and the register file, ALU and data memory.
//
// Fetch handshake:
//   INSTR/INSTR_VALID are inputs and INSTR_READY is the output.
//   FLUSH drops the instruction offered at the same edge.
//
// Register file:
//   READREG1, READREG2 and WRITEREG are the addresses.
//   WRITEENABLE is the write strobe.
//
// ALU controls:
//   IMMEDIATE, ALUOP, MUX_2C and MUX_IM.
//
// Write-back mux:
//   SEL_MUX_WRITE selects the write-back source.
//
// Control flow:
//   BRANCH, BRANCH_NE and JUMP.
//
// Data memory:
//   READ and WRITE are the commands.
//   BUSYWAIT is the stall input.
//
// Status:
//   OUT_VALID marks live decoded outputs.
//   ILLEGAL flags an unknown opcode.
//   RETIRED counts completed instructions.
//
// RESET is synchronous and active-high.
module decode_ctrl_stage #(
  parameter int REG_ADDR_W = 3,
  parameter int IMM_W      = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           INSTR,
  input  logic                  INSTR_VALID,
  output logic                  INSTR_READY,
  input  logic                  FLUSH,
  input  logic                  BUSYWAIT,
  output logic [REG_ADDR_W-1:0] READREG1,
  output logic [REG_ADDR_W-1:0] READREG2,
  output logic [REG_ADDR_W-1:0] WRITEREG,
  output logic [IMM_W-1:0]      IMMEDIATE,
  output logic [3:0]            ALUOP,
  output logic                  MUX_2C,
  output logic                  MUX_IM,
  output logic                  SEL_MUX_WRITE,
  output logic                  BRANCH,
  output logic                  BRANCH_NE,
  output logic                  JUMP,
  output logic                  WRITEENABLE,
  output logic                  READ,
  output logic                  WRITE,
  output logic                  OUT_VALID,
  output logic                  ILLEGAL,
  output logic [CNT_W-1:0]      RETIRED
);

  typedef enum logic [1:0] {IDLE, EXEC, MEM} state_t;

  typedef struct packed {
    logic [3:0] aluop;
    logic       mux_2c;
    logic       mux_im;
    logic       sel_mux_write;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic       we;
    logic       rd;
    logic       wr;
    logic       illegal;
  } ctrl_t;

  // Opcode table; defaults are register operand 2 and ALU write-back.
  function automatic ctrl_t decode(input logic [7:0] op);
    ctrl_t c;
    c               = '0;
    c.mux_im        = 1'b1;
    c.sel_mux_write = 1'b1;
    case (op)
      8'h00: begin c.mux_im = 1'b0; c.we = 1'b1; end
      8'h01: c.we = 1'b1;
      8'h02: begin c.aluop = 4'd1; c.we = 1'b1; end
      8'h03: begin c.aluop = 4'd1; c.mux_2c = 1'b1; c.we = 1'b1; end
      8'h04: begin c.aluop = 4'd2; c.we = 1'b1; end
      8'h05: begin c.aluop = 4'd3; c.we = 1'b1; end
      8'h06: c.jump = 1'b1;
      8'h07: begin c.branch = 1'b1; c.aluop = 4'd1; c.mux_2c = 1'b1; end
      8'h08: begin c.rd = 1'b1; c.sel_mux_write = 1'b0; c.we = 1'b1; end
      8'h09: begin
        c.rd = 1'b1; c.sel_mux_write = 1'b0; c.we = 1'b1; c.mux_im = 1'b0;
      end
      8'h0A: c.wr = 1'b1;
      8'h0B: begin c.wr = 1'b1; c.mux_im = 1'b0; end
      8'h0C: begin c.branch_ne = 1'b1; c.aluop = 4'd1; c.mux_2c = 1'b1; end
      8'h0D: begin c.aluop = 4'd4; c.mux_im = 1'b0; c.we = 1'b1; end
      8'h0E: begin c.aluop = 4'd5; c.mux_im = 1'b0; c.we = 1'b1; end
      8'h0F: begin c.aluop = 4'd6; c.mux_im = 1'b0; c.we = 1'b1; end
      8'h10: begin c.aluop = 4'd7; c.mux_im = 1'b0; c.we = 1'b1; end
      8'h11: begin c.aluop = 4'd8; c.we = 1'b1; end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  state_t state;
  ctrl_t  ctrl_r;
  ctrl_t  dec;
  logic   stall;
  logic   accept;
  logic   retire;
  logic   unused_instr;

  // Only the low REG_ADDR_W bits of each byte field are significant.
  assign unused_instr = ^INSTR;

  always_comb begin
    dec         = decode(INSTR[31:24]);
    stall       = (state == MEM) && BUSYWAIT;
    INSTR_READY = !RESET && !stall;
    accept      = INSTR_VALID && INSTR_READY && !FLUSH;
    retire      = (state == EXEC) || ((state == MEM) && !BUSYWAIT);
    // A load writes back only in its final, non-stalled MEM cycle.
    WRITEENABLE = OUT_VALID && ctrl_r.we && !stall;
  end

  assign ALUOP         = ctrl_r.aluop;
  assign MUX_2C        = ctrl_r.mux_2c;
  assign MUX_IM        = ctrl_r.mux_im;
  assign SEL_MUX_WRITE = ctrl_r.sel_mux_write;
  assign BRANCH        = ctrl_r.branch;
  assign BRANCH_NE     = ctrl_r.branch_ne;
  assign JUMP          = ctrl_r.jump;
  assign READ          = ctrl_r.rd;
  assign WRITE         = ctrl_r.wr;
  assign ILLEGAL       = ctrl_r.illegal;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      ctrl_r    <= '0;
      OUT_VALID <= 1'b0;
      READREG1  <= '0;
      READREG2  <= '0;
      WRITEREG  <= '0;
      IMMEDIATE <= '0;
      RETIRED   <= '0;
    end else begin
      if (retire) RETIRED <= RETIRED + CNT_W'(1);
      // A stalled memory op holds everything; FLUSH cannot cancel it.
      if (!stall) begin
        if (accept) begin
          state     <= (dec.rd || dec.wr) ? MEM : EXEC;
          ctrl_r    <= dec;
          OUT_VALID <= 1'b1;
          READREG1  <= INSTR[8 +: REG_ADDR_W];
          READREG2  <= INSTR[0 +: REG_ADDR_W];
          WRITEREG  <= INSTR[16 +: REG_ADDR_W];
          IMMEDIATE <= INSTR[IMM_W-1:0];
        end else begin
          state     <= IDLE;
          ctrl_r    <= '0;
          OUT_VALID <= 1'b0;
          READREG1  <= '0;
          READREG2  <= '0;
          WRITEREG  <= '0;
          IMMEDIATE <= '0;
        end
      end
    end
  end

endmodule
